cardinal_nic_fifo: RTL
======================

# cardinal_nic_fifo

Parametrised network interface controller between one cardinal_cpu core and one gold_ring node port. It is the next-generation drop-in for the single-entry cardinal_nic. It provides a DEPTH-entry input channel FIFO and a DEPTH-entry output channel FIFO instead of one-packet buffers. The processor sees a memory-mapped 4-register window; the ring side uses send/ready handshakes gated by the ring polarity.

## Interface
- DATA_WIDTH, 64, packet/word width; bits indexed [0:DATA_WIDTH-1], bit 0 = VC bit.
- DEPTH, 4, entries per FIFO; power of two, 2..128.
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- addr  input  2  register select: 0 input buffer, 1 input status, 2 output buffer, 3 output status.
- d_in  input  DATA_WIDTH  processor write data.
- d_out  output  DATA_WIDTH  processor read data (combinational).
- nicEn  input  1  access enable.
- nicEnWr  input  1  1 = write, 0 = read (qualified by nicEn).
- net_si  input  1  ring delivers packet this cycle.
- net_ri  output  1  NIC can accept a ring packet.
- net_di  input  DATA_WIDTH  packet from ring.
- net_so  output  1  NIC injects packet this cycle.
- net_ro  input  1  ring can accept a packet.
- net_do  output  DATA_WIDTH  packet to ring.
- net_polarity  input  1  ring router polarity.

## Operation
- Input FIFO (ring -> CPU): push on net_si & net_ri, storing net_di. net_ri = ~in_full & ~reset.
- Output FIFO (CPU -> ring): push on nicEn & nicEnWr & addr==2 & ~out_full, storing d_in. A write while full is dropped with no state change.
- Injection: net_so = ~out_empty & net_ro & (head[0] == net_polarity) & ~reset. net_do = output head whenever non-empty, else 0. Pop occurs on the same edge that net_so is high.
- Reads (nicEn & ~nicEnWr):
  - addr 0: d_out = input head; pop at edge if non-empty. Reading when empty returns 0 with no pop.
  - addr 1: d_out bit DATA_WIDTH-1 = ~in_empty.
  - addr 3: d_out bit DATA_WIDTH-1 = out_full.
  - addr 2: returns 0.
  - Other status bits are 0 unless NIC_OCCUPANCY_EN is defined.
- When nicEn = 0, d_out = 0. Writes to addr 0, 1, 3 are ignored.
- FIFOs are circular buffers with pointers of log2(DEPTH)+1 bits.
  - full: pointers differ only in the MSB.
  - empty: pointers are equal.
  - Pointers wrap modulo 2*DEPTH.
- Simultaneous push and pop in the same FIFO is legal whenever the FIFO is not empty/full per pre-edge flags. Occupancy is unchanged.
- Full/empty flags are evaluated pre-edge:
  - Pop and push on a full output FIFO: the push is dropped.
  - Pop and push on an empty input FIFO: the pop does not occur and d_out is 0.

## Timing
- Reset values: pointers 0, both FIFOs empty, net_so 0, net_ri 0 while reset is high, net_do 0, d_out 0.
- Reset mid-operation discards all buffered packets on the next edge. Storage contents need not be cleared.
- Ring-to-CPU latency: a packet pushed at edge N is readable at addr 0 in cycle N+1, and the status flag goes to 1 in cycle N+1.
- CPU-to-ring latency: a write at edge N can be injected earliest in cycle N+1, once polarity matches and net_ro is 1.
- Wrong polarity stalls the head packet. There is no reordering and no head-of-line bypass.
- Throughput: one push and one pop per FIFO per cycle.

## Configuration
- NIC_OCCUPANCY_EN:
  - Defined: status reads additionally report the FIFO entry count (0..DEPTH) as an 8-bit unsigned field in bits DATA_WIDTH-9..DATA_WIDTH-2, with the LSB at DATA_WIDTH-2. addr 1 reports the input FIFO count; addr 3 reports the output FIFO count.
  - Undefined: those bits read 0, and no count logic is instantiated.

## Test plan
- Reset, then idle: net_ri=1, net_so=0, addr 1 read returns 0, addr 3 read returns 0. With the macro defined, count is 0.
- Fill and overflow, DEPTH=4: write 0x1...01, 0x1...02, 0x1...03, 0x1...04, 0x1...05 to addr 2 with net_ro=0. Addr 3 flag is 1 after the 4th write; the 5th write is dropped.
- Drain with polarity: continue the fill-and-overflow case with net_polarity toggling every cycle and net_ro=1. Exactly 4 packets leave, in order, each only in cycles where polarity equals bit 0. Addr 3 then reads 0.
- Ring delivery: drive net_si with 4 packets back-to-back. net_ri drops to 0 after the 4th, and a 5th net_si is not accepted. Four addr 0 reads return the packets in order; a 5th addr 0 read returns 0.
- Simultaneous traffic: keep the input FIFO at 2 entries while pushing and popping the same cycle for 10 cycles. Occupancy stays at 2 and the data order is preserved.
- Mid-stream reset: with both FIFOs holding 3 entries, pulse reset for 1 cycle. Both FIFOs read as empty and net_so stays 0 afterwards.

Source files
------------

// File: rtl/cardinal_nic_fifo.sv
// CPU <-> gold_ring NIC with DEPTH-entry circular FIFOs in each direction.
// Optional macro NIC_OCCUPANCY_EN adds 8-bit entry counts to the status reads.
module cardinal_nic_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] in_wr_ptr_reg, in_wr_ptr_next, in_rd_ptr_reg, in_rd_ptr_next;
  logic [PW-1:0] out_wr_ptr_reg, out_wr_ptr_next, out_rd_ptr_reg, out_rd_ptr_next;

  logic [0:DATA_WIDTH-1] in_mem  [DEPTH];
  logic [0:DATA_WIDTH-1] out_mem [DEPTH];

  logic                  in_full, in_empty, out_full, out_empty;
  logic                  in_push, in_pop, out_push, out_pop;
  logic [0:DATA_WIDTH-1] in_head, out_head;

  // Full when the wrap bits differ but the index bits match.
  assign in_empty  = (in_wr_ptr_reg == in_rd_ptr_reg);
  assign in_full   = (in_wr_ptr_reg[AW] != in_rd_ptr_reg[AW]) &&
                     (in_wr_ptr_reg[AW-1:0] == in_rd_ptr_reg[AW-1:0]);
  assign out_empty = (out_wr_ptr_reg == out_rd_ptr_reg);
  assign out_full  = (out_wr_ptr_reg[AW] != out_rd_ptr_reg[AW]) &&
                     (out_wr_ptr_reg[AW-1:0] == out_rd_ptr_reg[AW-1:0]);

  assign in_head  = in_mem[in_rd_ptr_reg[AW-1:0]];
  assign out_head = out_mem[out_rd_ptr_reg[AW-1:0]];

  assign net_ri   = !in_full && !reset;
  assign in_push  = net_si && net_ri;
  assign in_pop   = nicEn && !nicEnWr && (addr == 2'd0) && !in_empty;
  assign out_push = nicEn && nicEnWr && (addr == 2'd2) && !out_full;

  // The head packet only leaves when its VC bit matches the ring polarity.
  assign net_so  = !out_empty && net_ro && (out_head[0] == net_polarity) && !reset;
  assign out_pop = net_so;
  assign net_do  = (out_empty || reset) ? '0 : out_head;

  always_comb begin
    in_wr_ptr_next  = in_push  ? in_wr_ptr_reg  + PW'(1) : in_wr_ptr_reg;
    in_rd_ptr_next  = in_pop   ? in_rd_ptr_reg  + PW'(1) : in_rd_ptr_reg;
    out_wr_ptr_next = out_push ? out_wr_ptr_reg + PW'(1) : out_wr_ptr_reg;
    out_rd_ptr_next = out_pop  ? out_rd_ptr_reg + PW'(1) : out_rd_ptr_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wr_ptr_reg  <= '0;
      in_rd_ptr_reg  <= '0;
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
    end else begin
      in_wr_ptr_reg  <= in_wr_ptr_next;
      in_rd_ptr_reg  <= in_rd_ptr_next;
      out_wr_ptr_reg <= out_wr_ptr_next;
      out_rd_ptr_reg <= out_rd_ptr_next;
    end
  end

  // Storage is not cleared by reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (in_push)
      in_mem[in_wr_ptr_reg[AW-1:0]] <= net_di;
    if (out_push)
      out_mem[out_wr_ptr_reg[AW-1:0]] <= d_in;
  end

`ifdef NIC_OCCUPANCY_EN
  logic [PW-1:0] in_count, out_count;
  logic [7:0]    in_count8, out_count8;
  assign in_count   = in_wr_ptr_reg - in_rd_ptr_reg;
  assign out_count  = out_wr_ptr_reg - out_rd_ptr_reg;
  assign in_count8  = 8'(in_count);
  assign out_count8 = 8'(out_count);
`endif

  always_comb begin
    d_out = '0;
    if (nicEn && !nicEnWr && !reset) begin
      case (addr)
        2'd0: if (!in_empty) d_out = in_head;
        2'd1: begin
          d_out[DATA_WIDTH-1] = !in_empty;
`ifdef NIC_OCCUPANCY_EN
          d_out[DATA_WIDTH-9:DATA_WIDTH-2] = in_count8;
`endif
        end
        2'd3: begin
          d_out[DATA_WIDTH-1] = out_full;
`ifdef NIC_OCCUPANCY_EN
          d_out[DATA_WIDTH-9:DATA_WIDTH-2] = out_count8;
`endif
        end
        default: d_out = '0;
      endcase
    end
  end

endmodule
